// File: rtl/r2b_pkg.sv
// rtl/r2b_pkg.sv - shared constants, FSM state types and sizing helpers for raster_to_block
package r2b_pkg;

    localparam int BLOCK_SIZE = 8;
    localparam int LOG2_BLOCK = 3;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} w_state_t;
    typedef enum logic       {R_IDLE, R_READ}         r_state_t;

    typedef logic bank_t;

    // Column field width inside one strip row.
    function automatic int col_width(input int max_width);
        return $clog2(max_width);
    endfunction

    // Strip RAM address: {bank, row, col}.
    function automatic int addr_width(input int max_width);
        return 1 + LOG2_BLOCK + col_width(max_width);
    endfunction

    function automatic bank_t other_bank(input bank_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/r2b_strip_ram.sv
// rtl/r2b_strip_ram.sv - simple dual-port strip RAM, one write port, one registered read port
// Ports: clk_i; wr_en_i/wr_addr_i/wr_data_i write port; rd_en_i/rd_addr_i read request;
//        rd_data_o read data, valid the cycle after rd_en_i.
module r2b_strip_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 14
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/raster_to_block.sv
// rtl/raster_to_block.sv - raster RGB stream to 8x8 block stream via ping-pong strip RAM
// Optional feature macro: R2B_FRAME_CHECK_EN (adds sticky frame_err output).
// Ports: clk, rst_n (async active-low); frame_width/frame_height sampled on accepted s_sof;
//        s_valid/s_ready/s_data/s_sof raster input; data_out/data_valid block output with
//        start_data, start_of_frame, end_of_frame markers; blocks_per_frame per frame.
module raster_to_block
    import r2b_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WIDTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sof,
`ifdef R2B_FRAME_CHECK_EN
    output logic                  frame_err,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  start_data,
    output logic                  start_of_frame,
    output logic                  end_of_frame,
    output logic [31:0]           blocks_per_frame
);

    localparam int COL_W  = col_width(MAX_WIDTH);
    localparam int BLK_W  = COL_W - LOG2_BLOCK;
    localparam int ADDR_W = addr_width(MAX_WIDTH);
    localparam logic [LOG2_BLOCK-1:0] ROW_LAST = LOG2_BLOCK'(BLOCK_SIZE - 1);

    // Writer state
    w_state_t          w_state_q;
    bank_t             wbank_q;
    logic [LOG2_BLOCK-1:0] wrow_q;
    logic [COL_W-1:0]  wcol_q, wlast_col_q;
    logic [12:0]       wstrip_q, hlast_q;
    logic [31:0]       blocks_q;

    // Bank handshake and per-bank frame context, so the reader's markers follow
    // the frame that filled the bank even after the writer has moved on.
    logic [1:0]        bank_full_q, bank_full_d;
    logic [1:0]        bank_first_q, bank_last_q;
    logic [BLK_W-1:0]  bank_lastblk_q [2];

    // Reader state
    r_state_t          r_state_q;
    bank_t             rbank_q;
    logic [LOG2_BLOCK-1:0] rrow_q, rcol_q;
    logic [BLK_W-1:0]  rblk_q;

    // Read pipeline: stage 1 aligns with RAM data, stage 2 is the output register.
    logic v1_q, sd1_q, sof1_q, eof1_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic valid_q, sd_q, sof_q, eof_q;

    logic accept, dims_ok, sof_start, start_ok, fill_px, strip_done, wr_en;
    logic rd_issue, rd_last;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign s_ready = (w_state_q != W_WAIT) && !bank_full_q[wbank_q];
    assign accept  = s_valid && s_ready;

`ifdef R2B_FRAME_CHECK_EN
    assign dims_ok = (frame_width[2:0] == 3'd0) && (frame_height[2:0] == 3'd0) &&
                     (frame_width != 16'd0) && (frame_height != 16'd0) &&
                     (frame_width <= 16'(MAX_WIDTH));
    // A mid-frame s_sof abandons the partial strip and restarts on the new frame.
    assign sof_start = accept && s_sof && ((w_state_q == W_IDLE) || (w_state_q == W_FILL));
`else
    logic unused_dim_bits;
    assign unused_dim_bits = ^{frame_width[2:0], frame_height[2:0]};
    assign dims_ok   = 1'b1;
    assign sof_start = accept && s_sof && (w_state_q == W_IDLE);
`endif

    assign start_ok   = sof_start && dims_ok;
    assign fill_px    = accept && (w_state_q == W_FILL) && !sof_start;
    assign strip_done = fill_px && (wcol_q == wlast_col_q) && (wrow_q == ROW_LAST);
    assign wr_en      = start_ok || fill_px;
    assign wr_addr    = start_ok ? {wbank_q, {LOG2_BLOCK{1'b0}}, {COL_W{1'b0}}}
                                 : {wbank_q, wrow_q, wcol_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q         <= W_IDLE;
            wbank_q           <= 1'b0;
            wrow_q            <= '0;
            wcol_q            <= '0;
            wlast_col_q       <= '0;
            wstrip_q          <= '0;
            hlast_q           <= '0;
            blocks_q          <= '0;
            bank_first_q      <= '0;
            bank_last_q       <= '0;
            bank_lastblk_q[0] <= '0;
            bank_lastblk_q[1] <= '0;
        end else if (start_ok) begin
            // The s_sof pixel itself lands at column 0.
            w_state_q   <= W_FILL;
            wrow_q      <= '0;
            wcol_q      <= COL_W'(1);
            wstrip_q    <= '0;
            wlast_col_q <= {frame_width[COL_W-1:LOG2_BLOCK] - BLK_W'(1), {LOG2_BLOCK{1'b1}}};
            hlast_q     <= frame_height[15:3] - 13'd1;
            blocks_q    <= 32'(frame_width[15:3]) * 32'(frame_height[15:3]);
        end else if (sof_start) begin
            w_state_q <= W_IDLE;
        end else begin
            unique case (w_state_q)
                W_IDLE: ;
                W_FILL: begin
                    if (fill_px) begin
                        if (wcol_q == wlast_col_q) begin
                            wcol_q <= '0;
                            if (wrow_q == ROW_LAST) begin
                                wrow_q                  <= '0;
                                wbank_q                 <= other_bank(wbank_q);
                                wstrip_q                <= wstrip_q + 13'd1;
                                bank_first_q[wbank_q]   <= (wstrip_q == 13'd0);
                                bank_last_q[wbank_q]    <= (wstrip_q == hlast_q);
                                bank_lastblk_q[wbank_q] <= wlast_col_q[COL_W-1:LOG2_BLOCK];
                                if (wstrip_q == hlast_q) begin
                                    w_state_q <= W_IDLE;
                                end else if (bank_full_q[other_bank(wbank_q)]) begin
                                    w_state_q <= W_WAIT;
                                end
                            end else begin
                                wrow_q <= wrow_q + LOG2_BLOCK'(1);
                            end
                        end else begin
                            wcol_q <= wcol_q + COL_W'(1);
                        end
                    end
                end
                W_WAIT: begin
                    if (!bank_full_q[wbank_q]) begin
                        w_state_q <= W_FILL;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

`ifdef R2B_FRAME_CHECK_EN
    logic frame_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else if (sof_start && ((w_state_q == W_FILL) || !dims_ok)) begin
            frame_err_q <= 1'b1;
        end
    end
    assign frame_err = frame_err_q;
`endif

    // Reader: column fastest, then row, then block across the strip.
    assign rd_issue = (r_state_q == R_READ);
    assign rd_last  = rd_issue && (rcol_q == ROW_LAST) && (rrow_q == ROW_LAST) &&
                      (rblk_q == bank_lastblk_q[rbank_q]);
    assign rd_addr  = {rbank_q, rrow_q, rblk_q, rcol_q};

    // Reader release and writer set always target different banks.
    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_last) begin
            bank_full_d[rbank_q] = 1'b0;
        end
        if (strip_done) begin
            bank_full_d[wbank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_q <= '0;
        end else begin
            bank_full_q <= bank_full_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            rbank_q   <= 1'b0;
            rrow_q    <= '0;
            rcol_q    <= '0;
            rblk_q    <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (bank_full_q[rbank_q]) begin
                        r_state_q <= R_READ;
                    end
                end
                R_READ: begin
                    if (rcol_q != ROW_LAST) begin
                        rcol_q <= rcol_q + LOG2_BLOCK'(1);
                    end else begin
                        rcol_q <= '0;
                        if (rrow_q != ROW_LAST) begin
                            rrow_q <= rrow_q + LOG2_BLOCK'(1);
                        end else begin
                            rrow_q <= '0;
                            if (rd_last) begin
                                rblk_q  <= '0;
                                rbank_q <= other_bank(rbank_q);
                                if (!bank_full_q[other_bank(rbank_q)]) begin
                                    r_state_q <= R_IDLE;
                                end
                            end else begin
                                rblk_q <= rblk_q + BLK_W'(1);
                            end
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sd1_q   <= 1'b0;
            sof1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sd_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            v1_q    <= rd_issue;
            sd1_q   <= rd_issue && (rcol_q == '0) && (rrow_q == '0);
            sof1_q  <= rd_issue && (rcol_q == '0) && (rrow_q == '0) && (rblk_q == '0) &&
                       bank_first_q[rbank_q];
            eof1_q  <= rd_last && bank_last_q[rbank_q];
            data_q  <= v1_q ? ram_rdata : '0;
            valid_q <= v1_q;
            sd_q    <= sd1_q;
            sof_q   <= sof1_q;
            eof_q   <= eof1_q;
        end
    end

    r2b_strip_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_strip_ram (
        .clk_i      (clk),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (s_data),
        .rd_en_i    (rd_issue),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (ram_rdata)
    );

    assign data_out         = data_q;
    assign data_valid       = valid_q;
    assign start_data       = sd_q;
    assign start_of_frame   = sof_q;
    assign end_of_frame     = eof_q;
    assign blocks_per_frame = blocks_q;

endmodule

// File: tb/tb_raster_to_block.sv
// tb/tb_raster_to_block.sv - scoreboard testbench for raster_to_block
module tb_raster_to_block;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] frame_width, frame_height;
    logic        s_valid, s_ready, s_sof;
    logic [31:0] s_data;
    logic [31:0] data_out;
    logic        data_valid, start_data, start_of_frame, end_of_frame;
    logic [31:0] blocks_per_frame;
`ifdef R2B_FRAME_CHECK_EN
    logic        frame_err;
`endif

    always #5 clk = ~clk;

    raster_to_block dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_width      (frame_width),
        .frame_height     (frame_height),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_sof            (s_sof),
`ifdef R2B_FRAME_CHECK_EN
        .frame_err        (frame_err),
`endif
        .data_out         (data_out),
        .data_valid       (data_valid),
        .start_data       (start_data),
        .start_of_frame   (start_of_frame),
        .end_of_frame     (end_of_frame),
        .blocks_per_frame (blocks_per_frame)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int out_cnt = 0;
    int last_acc = 0;
    int max_stall = 0;
    logic [34:0] exp_q [$];
    logic [34:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_out", data_out, mon_e[31:0]);
                check("start_data", 32'(start_data), 32'(mon_e[32]));
                check("start_of_frame", 32'(start_of_frame), 32'(mon_e[33]));
                check("end_of_frame", 32'(end_of_frame), 32'(mon_e[34]));
            end
        end
    end

    // Expected block order: strips top to bottom, blocks left to right, raster inside a block.
    task automatic push_frame(input int w, input int h, input int base);
        bit sd, sof, eof;
        int idx;
        for (int s = 0; s < h / 8; s++)
            for (int b = 0; b < w / 8; b++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        idx = (s * 8 + r) * w + b * 8 + c;
                        sd  = (r == 0) && (c == 0);
                        sof = sd && (b == 0) && (s == 0);
                        eof = (s == h / 8 - 1) && (b == w / 8 - 1) && (r == 7) && (c == 7);
                        exp_q.push_back({eof, sof, sd, 32'(base + idx)});
                    end
    endtask

    task automatic put_px(input logic [31:0] d, input logic sof);
        int stall = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && stall < 500) begin
            @(posedge clk); #1;
            stall++;
        end
        if (stall >= 500) check("s_ready_timeout", 32'(stall), 32'd0);
        if (stall > max_stall) max_stall = stall;
        last_acc = cyc + 1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int base, input bit gap);
        frame_width  = 16'(w);
        frame_height = 16'(h);
        for (int i = 0; i < w * h; i++) begin
            if (gap && i > 0) begin
                @(posedge clk); #1;
            end
            put_px(32'(base + i), (i == 0));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_data_out"}, data_out, 32'd0);
        check({tag, "_markers"}, 32'({start_data, start_of_frame, end_of_frame}), 32'd0);
        check({tag, "_blocks"}, blocks_per_frame, 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int c0;
        int lat;
        int n;
        rst_n        = 1'b0;
        s_valid      = 1'b0;
        s_sof        = 1'b0;
        s_data       = '0;
        frame_width  = 16'd0;
        frame_height = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("por");
`ifdef R2B_FRAME_CHECK_EN
        check("por_frame_err", 32'(frame_err), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 16x8, continuous input
        push_frame(16, 8, 0);
        send_frame(16, 8, 0, 1'b0);
        check("bpf_16x8", blocks_per_frame, 32'd2);
        wait_drain();

        // 16x16, continuous input
        max_stall = 0;
        c0 = out_cnt;
        push_frame(16, 16, 1000);
        send_frame(16, 16, 1000, 1'b0);
        check("bpf_16x16", blocks_per_frame, 32'd4);
        check("stall_le_2", 32'(max_stall <= 2), 32'd1);
        wait_drain();
        check("count_16x16", 32'(out_cnt - c0), 32'd256);

        // 8x8 with toggled s_valid, first-output latency
        push_frame(8, 8, 2000);
        send_frame(8, 8, 2000, 1'b1);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (data_valid) begin
                lat = cyc - last_acc;
                break;
            end
        end
        check("latency_8x8", 32'(lat), 32'd3);
        check("bpf_8x8", blocks_per_frame, 32'd1);
        wait_drain();

        // Reset in the middle of a 16x16 readout, then a clean 8x8 frame
        c0 = out_cnt;
        push_frame(16, 16, 3000);
        send_frame(16, 16, 3000, 1'b0);
        n = 0;
        while ((out_cnt - c0) < 150 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("midread_reached", 32'((out_cnt - c0) >= 150), 32'd1);
        apply_reset();
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_idle", 32'(data_valid), 32'd0);
        push_frame(8, 8, 4000);
        send_frame(8, 8, 4000, 1'b0);
        wait_drain();
        check("bpf_after_reset", blocks_per_frame, 32'd1);

`ifdef R2B_FRAME_CHECK_EN
        // s_sof at pixel 40 restarts the frame
        frame_width  = 16'd16;
        frame_height = 16'd8;
        for (int i = 0; i < 40; i++) put_px(32'(9000 + i), (i == 0));
        check("err_before_restart", 32'(frame_err), 32'd0);
        push_frame(16, 8, 5000);
        send_frame(16, 8, 5000, 1'b0);
        check("err_mid_sof", 32'(frame_err), 32'd1);
        wait_drain();

        // Illegal width 12: flagged and ignored
        apply_reset();
        check("err_cleared", 32'(frame_err), 32'd0);
        c0 = out_cnt;
        send_frame(12, 8, 6000, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        check("err_width12", 32'(frame_err), 32'd1);
        check("no_out_width12", 32'(out_cnt - c0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
